fetch_unit: RTL and testbench

Instruction-fetch front end sitting on the opposite side of the program counter. It consumes the current PC value and drives the PC's next-value and enable inputs. It also fetches instruction words from a variable-latency instruction memory over a req/ack handshake. Fetched words are buffered in a 2-entry queue toward decode, and the unit handles redirects, bus errors and fetch timeouts.

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_buffer.sv | 69 ++++++
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   - FSM state encoding (IDLE, REQ, DRAIN, FAULT)
//   - fetch_entry_t: one buffered instruction word with its address
//   - reset PC, fault vector and instruction size constants
//   - next_addr(): sequential fetch address helper
package fetch_unit_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_REQ   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_FAULT = 2'd3;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] FAULT_VEC   = 32'h0000_00FF;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Address of the instruction following 'addr' (wraps modulo 2^32).
    function automatic logic [31:0] next_addr(input logic [31:0] addr);
        return addr + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {instruction, address} entries toward decode.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   push, wdata   write an entry at the tail (ignored when full)
//   pop           remove the head entry (ignored when empty)
//   flush         discard all entries; overrides push and pop
//   rdata         head entry (meaningful only when !empty)
//   count         number of valid entries
//   empty, full   occupancy flags
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // NOTE: the storage array has no reset; 'empty' qualifies the head, so
    // only the pointers and count need a defined value after reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the PC's next value/enable, fetches words
// from a variable-latency memory (one outstanding request) and queues them for
// decode. Handles redirects, bus errors, misaligned PCs and fetch timeouts.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   pc_addr                    current PC register value
//   pc_next, pc_en             next PC value / enable (pc_en=0 loads the fault vector)
//   redir_valid, redir_target  branch/jump redirect strobe and address
//   imem_req, imem_addr        memory request (held until ack) and its address
//   imem_ack, imem_err, imem_rdata  memory response, error and data
//   instr_valid, instr, instr_pc    buffer head toward decode
//   instr_ready                decode accepts the head this cycle
//   fault                      one-cycle pulse while handling a fetch fault
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH          = 2,
    parameter int          TIMEOUT        = 15,
    parameter logic [31:0] FAULT_VEC_NOTE = FAULT_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    output logic [31:0] pc_next,
    output logic        pc_en,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_err,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fault
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state;
    state_t         state_nx;
    logic [TW-1:0]  timer;
    logic           load_req;
    logic [31:0]    req_addr;
    logic           clr_timer;

    logic           redir;
    logic           good_ack;
    logic           timed_out;
    logic           pop;
    logic           flush;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_after;
    logic           buf_empty;
    logic           buf_full;
    fetch_entry_t   head;

    // A redirect while faulting is ignored: the fault vector wins.
    assign redir     = redir_valid && (state != ST_FAULT);
    // Redirect outranks a same-cycle ack, so that word is dropped.
    assign good_ack  = (state == ST_REQ) && imem_ack && !imem_err && !redir_valid;
    assign timed_out = (timer == TW'(TIMEOUT - 1));
    assign pop       = instr_valid && instr_ready;
    assign flush     = redir || (state == ST_FAULT);
    // Occupancy after this cycle's push, used to decide on a back-to-back request.
    assign count_after = count + CW'(1) - CW'(pop);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statement can infer a latch.
        state_nx = state;
        load_req = 1'b0;
        req_addr = pc_addr;
        case (state)
            ST_IDLE: begin
                // During a redirect pc_addr is stale; wait for the new PC.
                if (!redir) begin
                    if (pc_addr[1:0] != 2'b00) begin
                        state_nx = ST_FAULT;
                    end else if (!buf_full) begin
                        state_nx = ST_REQ;
                        load_req = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (redir) begin
                    state_nx = imem_ack ? ST_IDLE : ST_DRAIN;
                end else if (imem_ack) begin
                    if (imem_err) begin
                        state_nx = ST_FAULT;
                    end else if (count_after < CW'(DEPTH)) begin
                        state_nx = ST_REQ;
                        load_req = 1'b1;
                        req_addr = next_addr(imem_addr);
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else if (timed_out) begin
                    state_nx = ST_FAULT;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_nx = ST_IDLE;
                end else if (timed_out) begin
                    state_nx = ST_FAULT;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign clr_timer = load_req || ((state_nx == ST_DRAIN) && (state != ST_DRAIN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            imem_addr <= RESET_PC;
            timer     <= '0;
        end else begin
            state <= state_nx;
            if (load_req) begin
                imem_addr <= req_addr;
            end
            if (clr_timer) begin
                timer <= '0;
            end else if (imem_req && !imem_ack && (timer != TW'(TIMEOUT))) begin
                timer <= timer + TW'(1);
            end
        end
    end

    always_comb begin
        pc_en   = 1'b1;
        pc_next = pc_addr;
        if (state == ST_FAULT) begin
            pc_en   = 1'b0;
            pc_next = FAULT_VEC_NOTE;
        end else if (redir_valid) begin
            pc_next = redir_target;
        end else if (good_ack) begin
            pc_next = next_addr(imem_addr);
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk   (clk),
        .rst   (rst),
        .push  (good_ack),
        .wdata ('{instr: imem_rdata, pc: imem_addr}),
        .pop   (pop),
        .flush (flush),
        .rdata (head),
        .count (count),
        .empty (buf_empty),
        .full  (buf_full)
    );

    assign imem_req    = (state == ST_REQ) || (state == ST_DRAIN);
    assign fault       = (state == ST_FAULT);
    assign instr_valid = !buf_empty;
    assign instr       = instr_valid ? head.instr : 32'h0;
    assign instr_pc    = instr_valid ? head.pc    : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a PC register and a configurable-latency
// memory surround the DUT; per-cycle expectations come from hand-built tables.
module tb_fetch_unit;

    localparam logic [31:0] FVEC = 32'h0000_00FF;
    localparam logic [31:0] XMASK = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic [31:0] pc_addr;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_err;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fault;

    // memory model controls
    logic        mem_en;
    logic [7:0]  mem_lat;
    logic        err_en;
    logic [31:0] err_addr;
    logic        force_ack;
    logic [7:0]  wait_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pc_addr      (pc_addr),
        .pc_next      (pc_next),
        .pc_en        (pc_en),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_err     (imem_err),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .fault        (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register: loads pc_next when enabled, the fault vector otherwise.
    always @(posedge clk or negedge rst) begin
        if (!rst)       pc_addr <= 32'h0;
        else if (pc_en) pc_addr <= pc_next;
        else            pc_addr <= FVEC;
    end

    // Memory: acks 'mem_lat' cycles after the request rises (0 = same cycle).
    assign imem_ack   = force_ack || (imem_req && mem_en && (wait_cnt >= mem_lat));
    assign imem_err   = imem_ack && err_en && (imem_addr == err_addr);
    assign imem_rdata = imem_addr ^ XMASK;

    always @(posedge clk or negedge rst) begin
        if (!rst)                        wait_cnt <= 8'd0;
        else if (!imem_req || imem_ack)  wait_cnt <= 8'd0;
        else if (wait_cnt != 8'hFF)      wait_cnt <= wait_cnt + 8'd1;
    end

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        logic        rdy;
        logic        fack;
        int          reps;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_pcn;
        logic        e_pcen;
        logic        e_fault;
    } vec_t;

    vec_t vec[$];

    task automatic add(input logic redir, input logic [31:0] tgt, input logic rdy,
                       input logic fack, input int reps, input logic e_req,
                       input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_ipc, input logic [31:0] e_pcn,
                       input logic e_pcen, input logic e_fault);
        vec_t v;
        v.redir = redir; v.tgt = tgt; v.rdy = rdy; v.fack = fack; v.reps = reps;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_ipc = e_ipc;
        v.e_pcn = e_pcn; v.e_pcen = e_pcen; v.e_fault = e_fault;
        vec.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mem_cfg(input logic en, input logic [7:0] lat, input logic eerr,
                           input logic [31:0] eaddr);
        mem_en = en; mem_lat = lat; err_en = eerr; err_addr = eaddr;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redir_valid = 1'b0; redir_target = 32'h0; instr_ready = 1'b0; force_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Apply rows [lo,hi): drive inputs, let logic settle, compare, next cycle.
    task automatic run_table(input string scen, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            for (int r = 0; r < vec[i].reps; r++) begin
                string tag;
                redir_valid  = vec[i].redir;
                redir_target = vec[i].tgt;
                instr_ready  = vec[i].rdy;
                force_ack    = vec[i].fack;
                #1;
                tag = $sformatf("%s row%0d.%0d", scen, i - lo, r);
                check({tag, " imem_req"},    32'(imem_req),    32'(vec[i].e_req));
                check({tag, " imem_addr"},   imem_addr,        vec[i].e_addr);
                check({tag, " instr_valid"}, 32'(instr_valid), 32'(vec[i].e_valid));
                check({tag, " instr_pc"},    instr_pc,         vec[i].e_valid ? vec[i].e_ipc : 32'h0);
                check({tag, " instr"},       instr,            vec[i].e_valid ? (vec[i].e_ipc ^ XMASK) : 32'h0);
                check({tag, " pc_next"},     pc_next,          vec[i].e_pcn);
                check({tag, " pc_en"},       32'(pc_en),       32'(vec[i].e_pcen));
                check({tag, " fault"},       32'(fault),       32'(vec[i].e_fault));
                @(negedge clk);
            end
        end
        force_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s1, e1, s2, e2, s3, e3, s4, e4, s5, e5;

    initial begin
        rst = 1'b0;
        mem_cfg(1'b1, 8'd0, 1'b0, 32'h0);

        // redir tgt rdy fack reps | req addr valid ipc pc_next pc_en fault
        // 1: zero-wait stream, then a redirect colliding with an ack and a pop
        s1 = vec.size();
        add(0, 0,     1, 0, 1,  0, 32'h00, 0, 32'h00, 32'h00, 1, 0);
        add(0, 0,     1, 0, 1,  1, 32'h00, 0, 32'h00, 32'h04, 1, 0);
        add(0, 0,     1, 0, 1,  1, 32'h04, 1, 32'h00, 32'h08, 1, 0);
        add(0, 0,     1, 0, 1,  1, 32'h08, 1, 32'h04, 32'h0C, 1, 0);
        add(0, 0,     1, 0, 1,  1, 32'h0C, 1, 32'h08, 32'h10, 1, 0);
        add(0, 0,     1, 0, 1,  1, 32'h10, 1, 32'h0C, 32'h14, 1, 0);
        add(1, 32'h40,1, 0, 1,  1, 32'h14, 1, 32'h10, 32'h40, 1, 0);
        add(0, 0,     1, 0, 1,  0, 32'h14, 0, 32'h00, 32'h40, 1, 0);
        add(0, 0,     1, 0, 1,  1, 32'h40, 0, 32'h00, 32'h44, 1, 0);
        add(0, 0,     1, 0, 1,  1, 32'h44, 1, 32'h40, 32'h48, 1, 0);
        e1 = vec.size();

        // 2: back-pressure fills both entries, then drains 0, 4 and resumes at 8
        s2 = vec.size();
        add(0, 0, 0, 0, 1,  0, 32'h00, 0, 32'h00, 32'h00, 1, 0);
        add(0, 0, 0, 0, 1,  1, 32'h00, 0, 32'h00, 32'h04, 1, 0);
        add(0, 0, 0, 0, 1,  1, 32'h04, 1, 32'h00, 32'h08, 1, 0);
        add(0, 0, 0, 0, 8,  0, 32'h04, 1, 32'h00, 32'h08, 1, 0);
        add(0, 0, 1, 0, 1,  0, 32'h04, 1, 32'h00, 32'h08, 1, 0);
        add(0, 0, 1, 0, 1,  0, 32'h04, 1, 32'h04, 32'h08, 1, 0);
        add(0, 0, 1, 0, 1,  1, 32'h08, 0, 32'h00, 32'h0C, 1, 0);
        add(0, 0, 1, 0, 1,  1, 32'h0C, 1, 32'h08, 32'h10, 1, 0);
        e2 = vec.size();

        // 3: redirect while a 3-cycle-latency request is in flight
        s3 = vec.size();
        add(0, 0,      1, 0, 1,  0, 32'h000, 0, 32'h000, 32'h000, 1, 0);
        add(0, 0,      1, 0, 1,  1, 32'h000, 0, 32'h000, 32'h000, 1, 0);
        add(1, 32'h100,1, 0, 1,  1, 32'h000, 0, 32'h000, 32'h100, 1, 0);
        add(0, 0,      1, 0, 1,  1, 32'h000, 0, 32'h000, 32'h100, 1, 0);
        add(0, 0,      1, 0, 1,  1, 32'h000, 0, 32'h000, 32'h100, 1, 0);
        add(0, 0,      1, 0, 1,  0, 32'h000, 0, 32'h000, 32'h100, 1, 0);
        add(0, 0,      1, 0, 3,  1, 32'h100, 0, 32'h000, 32'h100, 1, 0);
        add(0, 0,      1, 0, 1,  1, 32'h100, 0, 32'h000, 32'h104, 1, 0);
        add(0, 0,      1, 0, 1,  1, 32'h104, 1, 32'h100, 32'h104, 1, 0);
        e3 = vec.size();

        // 4: bus error at 0x20 with one entry buffered, then misaligned vector faults
        s4 = vec.size();
        add(1, 32'h18, 0, 0, 1,  0, 32'h00, 0, 32'h00, 32'h18, 1, 0);
        add(0, 0,      0, 0, 1,  0, 32'h00, 0, 32'h00, 32'h18, 1, 0);
        add(0, 0,      0, 0, 1,  1, 32'h18, 0, 32'h00, 32'h1C, 1, 0);
        add(0, 0,      0, 0, 1,  1, 32'h1C, 1, 32'h18, 32'h20, 1, 0);
        add(0, 0,      1, 0, 1,  0, 32'h1C, 1, 32'h18, 32'h20, 1, 0);
        add(0, 0,      0, 0, 1,  0, 32'h1C, 1, 32'h1C, 32'h20, 1, 0);
        add(0, 0,      0, 0, 1,  1, 32'h20, 1, 32'h1C, 32'h20, 1, 0);
        add(0, 0,      0, 0, 1,  0, 32'h20, 1, 32'h1C, FVEC,   0, 1);
        add(0, 0,      0, 0, 1,  0, 32'h20, 0, 32'h00, FVEC,   1, 0);
        add(1, 32'h200,0, 0, 1,  0, 32'h20, 0, 32'h00, FVEC,   0, 1);
        add(0, 0,      0, 0, 1,  0, 32'h20, 0, 32'h00, FVEC,   1, 0);
        e4 = vec.size();

        // 5: no ack: 15 waiting cycles, fault, then a late ack is ignored
        s5 = vec.size();
        add(0, 0, 1, 0, 1,   0, 32'h0, 0, 32'h0, 32'h0, 1, 0);
        add(0, 0, 1, 0, 15,  1, 32'h0, 0, 32'h0, 32'h0, 1, 0);
        add(0, 0, 1, 0, 1,   0, 32'h0, 0, 32'h0, FVEC,  0, 1);
        add(0, 0, 1, 1, 1,   0, 32'h0, 0, 32'h0, FVEC,  1, 0);
        add(0, 0, 1, 0, 1,   0, 32'h0, 0, 32'h0, FVEC,  0, 1);
        e5 = vec.size();

        mem_cfg(1'b1, 8'd0, 1'b0, 32'h0);  do_reset(); run_table("zero_wait", s1, e1);
        mem_cfg(1'b1, 8'd0, 1'b0, 32'h0);  do_reset(); run_table("backpressure", s2, e2);
        mem_cfg(1'b1, 8'd3, 1'b0, 32'h0);  do_reset(); run_table("redirect", s3, e3);
        mem_cfg(1'b1, 8'd0, 1'b1, 32'h20); do_reset(); run_table("bus_error", s4, e4);
        mem_cfg(1'b0, 8'd0, 1'b0, 32'h0);  do_reset(); run_table("timeout", s5, e5);

        // 6: asynchronous reset between edges while a request is outstanding
        mem_cfg(1'b1, 8'd0, 1'b0, 32'h0);
        do_reset();
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("areset pre imem_req",    32'(imem_req),    32'd1);
        check("areset pre instr_valid", 32'(instr_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("areset imem_req",    32'(imem_req),    32'd0);
        check("areset instr_valid", 32'(instr_valid), 32'd0);
        check("areset imem_addr",   imem_addr,        32'h0);
        check("areset instr",       instr,            32'h0);
        check("areset pc_en",       32'(pc_en),       32'd1);
        check("areset fault",       32'(fault),       32'd0);
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        check("areset late ack imem_req",    32'(imem_req),    32'd0);
        check("areset late ack instr_valid", 32'(instr_valid), 32'd0);
        force_ack = 1'b0;
        do_reset();
        run_table("after_reset", s1, s1 + 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
